// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmit data register among NUM_REQ byte-stream
// requesters. A requester is picked round-robin, its byte is latched, and
// the UART write strobe is raised as soon as the UART is not busy. The
// arbiter then waits for the UART to finish the frame before arbitrating
// again, so no byte is ever written while the UART is busy.
//
// Optional feature (compile-time macro UART_ARB_LINE_LOCK_EN):
//   After a byte other than 0x0A is accepted from requester i, the
//   arbiter locks onto i until i sends 0x0A or LOCK_TIMEOUT consecutive
//   IDLE cycles pass with req_valid[i] low. Without the macro the lock
//   logic is absent and lock_active is tied to 0.
//
// Handshake: requester i raises req_valid[i] and holds its byte on
// req_data[8i+7:8i] until req_ready[i] pulses; the byte transfers on the
// clock edge where req_valid[i] && req_ready[i]. req_ready is one-hot and
// combinational, and is only raised when the UART is not busy.
//
// Ports:
//   clk            in   clock
//   reset          in   asynchronous active-high reset
//   req_valid      in   [NUM_REQ]    byte pending per requester
//   req_data       in   [8*NUM_REQ]  byte i at bits [8i+7:8i]
//   req_ready      out  [NUM_REQ]    one-hot accept pulse
//   uart_dat_we    out  UART data write strobe
//   uart_dat_di    out  [32]  {24'b0, latched byte}
//   uart_dat_wait  in   UART busy (frame in progress or dummy frame)
//   busy           out  arbiter holds a byte or the UART is draining it
//   grant_id       out  [IW]  index of the most recently accepted requester
//   lock_active    out  line lock held (0 without UART_ARB_LINE_LOCK_EN)
//   dbg_state      out  [2]   FSM state: 0 IDLE, 1 ISSUE, 2 DRAIN
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       uart_dat_we,
  output logic [31:0]                uart_dat_di,
  input  logic                       uart_dat_wait,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       lock_active,
  output logic [1:0]                 dbg_state
);

  localparam int IW = $clog2(NUM_REQ);

  // Elaboration-time parameter range checks.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
  end
  if (LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 65535) begin : g_bad_timeout
    $error("uart_tx_arbiter: LOCK_TIMEOUT must be in 1..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      byte_q, byte_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   grant_q, grant_d;
  // High only in the first DRAIN cycle: the UART raises its wait one cycle
  // after the write, so wait is not trusted in that cycle.
  logic            drain_first_q, drain_first_d;

  logic [NUM_REQ-1:0] owner_mask;
  logic [NUM_REQ-1:0] elig;
  logic               win_found;
  logic [IW-1:0]      win_idx;
  logic [7:0]         win_byte;
  logic               accept;
  logic               lock_held;

`ifdef UART_ARB_LINE_LOCK_EN
  localparam logic [15:0] TMO_LIMIT = 16'(LOCK_TIMEOUT);
  logic        lock_q, lock_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] tmo_inc;

  assign lock_held = lock_q;
  // Saturating increment of the idle counter.
  assign tmo_inc   = (tmo_q == 16'hFFFF) ? tmo_q : (tmo_q + 16'd1);
`else
  assign lock_held = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Arbitration: eligible set and rotating-priority winner.
  // -------------------------------------------------------------------------
  always_comb begin
    owner_mask         = '0;
    owner_mask[last_q] = 1'b1;
    // The lock owner is always the last granted requester.
    elig = lock_held ? (req_valid & owner_mask) : req_valid;
  end

  // Search upward from last+1, wrapping, so the most recent winner has the
  // lowest priority on the next round.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      logic [IW-1:0] cand;
      cand = IW'((int'(last_q) + k) % NUM_REQ);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_byte = req_data[int'(win_idx)*8 +: 8];

  // A byte is accepted only in IDLE with the UART free. Reset blocks the
  // accept so no requester sees ready while the arbiter is held in reset.
  assign accept = (state_q == ST_IDLE) && win_found && !uart_dat_wait && !reset;

  // -------------------------------------------------------------------------
  // FSM process 1: state and datapath registers.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      byte_q        <= 8'h00;
      last_q        <= IW'(NUM_REQ - 1);
      grant_q       <= '0;
      drain_first_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_q        <= byte_d;
      last_q        <= last_d;
      grant_q       <= grant_d;
      drain_first_q <= drain_first_d;
    end
  end

`ifdef UART_ARB_LINE_LOCK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q <= 1'b0;
      tmo_q  <= 16'd0;
    end else begin
      lock_q <= lock_d;
      tmo_q  <= tmo_d;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // FSM process 2: next-state and datapath next values.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    drain_first_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // The UART may have become busy after IDLE sampled (a divider
        // write re-arms the dummy frame), so hold the byte until free.
        if (!uart_dat_wait) begin
          state_d       = ST_DRAIN;
          drain_first_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!drain_first_q && !uart_dat_wait) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_d  = byte_q;
    last_d  = last_q;
    grant_d = grant_q;
    if (accept) begin
      byte_d  = win_byte;
      last_d  = win_idx;
      grant_d = win_idx;
    end
  end

`ifdef UART_ARB_LINE_LOCK_EN
  // Lock set on every non-newline grant and cleared on a newline grant.
  // While locked and idle, the counter runs only while the owner has
  // nothing to send; the owner raising valid restarts the count.
  // Releasing the lock leaves last_q alone, so the pointer does not move.
  always_comb begin
    lock_d = lock_q;
    tmo_d  = tmo_q;
    if (accept) begin
      tmo_d  = 16'd0;
      lock_d = (win_byte != 8'h0A);
    end else if (state_q == ST_IDLE && lock_q) begin
      if (req_valid[last_q]) begin
        tmo_d = 16'd0;
      end else begin
        tmo_d = tmo_inc;
        if (tmo_inc >= TMO_LIMIT) lock_d = 1'b0;
      end
    end
  end
`endif

  // -------------------------------------------------------------------------
  // FSM process 3: outputs.
  // -------------------------------------------------------------------------
  always_comb begin
    req_ready   = '0;
    uart_dat_we = 1'b0;
    if (accept) req_ready[win_idx] = 1'b1;
    if (state_q == ST_ISSUE) uart_dat_we = !uart_dat_wait;
  end

  assign uart_dat_di = {24'b0, byte_q};
  assign busy        = (state_q != ST_IDLE);
  assign grant_id    = grant_q;
  assign lock_active = lock_held;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Bench for uart_tx_arbiter (NUM_REQ=4, LOCK_TIMEOUT=8). Contains a
// requester byte-queue model, a UART model that raises wait for a number
// of cycles after each write, and a cycle-level reference model of the
// arbitration rules (rotating pointer, lock, accept/issue/drain timing).
// Build with +define+UART_ARB_LINE_LOCK_EN to exercise the line lock.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int LT  = 8;
  localparam int CAP = 512;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [N-1:0]     req_valid;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             uart_dat_we;
  logic [31:0]      uart_dat_di;
  logic             uart_dat_wait;
  logic             busy;
  logic [1:0]       grant_id;
  logic             lock_active;
  logic [1:0]       dbg_state;

  uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(LT)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .uart_dat_we   (uart_dat_we),
    .uart_dat_di   (uart_dat_di),
    .uart_dat_wait (uart_dat_wait),
    .busy          (busy),
    .grant_id      (grant_id),
    .lock_active   (lock_active),
    .dbg_state     (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- requester model ----------------
  logic [7:0] rbuf [N][CAP];
  int         rhd  [N];
  int         rtail[N];

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      rhd[i]   = 0;
      rtail[i] = 0;
    end
  endtask

  task automatic push_byte(input int r, input logic [7:0] b);
    if (rtail[r] < CAP) begin
      rbuf[r][rtail[r]] = b;
      rtail[r]++;
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = (rhd[i] != rtail[i]);
      req_data[i*8 +: 8] = req_valid[i] ? rbuf[i][rhd[i]] : 8'h00;
    end
  endtask

  function automatic bit reqs_pending();
    for (int i = 0; i < N; i++) if (rhd[i] != rtail[i]) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- UART model ----------------
  int wait_cnt;
  int wait_len;
  bit force_wait;
  bit rand_wait;

  task automatic drive_uart();
    uart_dat_wait = force_wait || (wait_cnt > 0);
  endtask

  // ---------------- reference model ----------------
  int         ptr;
  bit         pend;        // byte accepted, strobe not yet issued
  int         drain_age;   // 0 none, 1 next cycle is first drain, 2 later drain
  int         gid;
  logic [7:0] cur_byte;
  bit         lock_on;
  int         owner;
  int         idle_cnt;
  int         cyc;

  logic [7:0] exp_q[$];       // scoreboard: bytes owed to the UART
  logic [7:0] uart_log[$];    // bytes seen on the UART
  int         dut_grant[$];   // requester index of each DUT accept
  int         accept_cyc[$];  // cycle number of each DUT accept

  task automatic model_reset();
    ptr       = N - 1;
    pend      = 1'b0;
    drain_age = 0;
    gid       = 0;
    cur_byte  = 8'h00;
    lock_on   = 1'b0;
    owner     = 0;
    idle_cnt  = 0;
    exp_q.delete();
  endtask

  function automatic int ul(input int i);
    return (i < uart_log.size()) ? int'(uart_log[i]) : -1;
  endfunction

  function automatic int gl(input int i);
    return (i < dut_grant.size()) ? dut_grant[i] : -1;
  endfunction

  // One clock cycle: sample at negedge, check against the model, advance
  // the model, then update stimulus 1 time unit after the posedge.
  task automatic step();
    logic [N-1:0] elig, exp_ready, rdy_seen;
    bit           idle_m, exp_we, we_seen;
    int           idx;
    @(negedge clk);
    idle_m = !pend && (drain_age == 0);
    elig   = req_valid;
    if (lock_on) begin
      elig        = '0;
      elig[owner] = req_valid[owner];
    end
    exp_ready = '0;
    idx       = -1;
    if (idle_m && elig != '0 && !uart_dat_wait) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (ptr + k) % N;
        if (idx < 0 && elig[c]) idx = c;
      end
      exp_ready[idx] = 1'b1;
    end
    exp_we = pend && !uart_dat_wait;

    chk("req_ready",   32'(req_ready),   32'(exp_ready));
    chk("uart_dat_we", 32'(uart_dat_we), 32'(exp_we));
    chk("busy",        32'(busy),        32'(!idle_m));
    chk("grant_id",    32'(grant_id),    32'(gid));
    chk("lock_active", 32'(lock_active), 32'(lock_on));
    chk("uart_dat_di", uart_dat_di,      {24'h0, cur_byte});

    rdy_seen = req_ready;
    we_seen  = uart_dat_we;
    if (rdy_seen != '0) begin
      for (int i = 0; i < N; i++) if (rdy_seen[i]) begin
        dut_grant.push_back(i);
        break;
      end
      accept_cyc.push_back(cyc);
    end
    if (we_seen) begin
      if (exp_q.size() == 0) fail("strobe_without_byte");
      else chk("uart_byte", 32'(uart_dat_di[7:0]), 32'(exp_q.pop_front()));
      uart_log.push_back(uart_dat_di[7:0]);
    end

    // model advance
    if (drain_age == 1) drain_age = 2;
    else if (drain_age == 2 && !uart_dat_wait) drain_age = 0;
    if (exp_we) begin
      pend      = 1'b0;
      drain_age = 1;
    end
`ifdef UART_ARB_LINE_LOCK_EN
    if (idle_m && lock_on) begin
      if (req_valid[owner]) idle_cnt = 0;
      else begin
        if (idle_cnt < 65535) idle_cnt++;
        if (idle_cnt >= LT) lock_on = 1'b0;
      end
    end
`endif
    if (idx >= 0) begin
      ptr      = idx;
      gid      = idx;
      cur_byte = rbuf[idx][rhd[idx]];
      exp_q.push_back(cur_byte);
      pend     = 1'b1;
`ifdef UART_ARB_LINE_LOCK_EN
      lock_on  = (cur_byte != 8'h0A);
      owner    = idx;
      idle_cnt = 0;
`endif
    end

    @(posedge clk);
    #1;
    cyc++;
    if (we_seen) wait_cnt = rand_wait ? int'($urandom_range(1, 6)) : wait_len;
    else if (wait_cnt > 0) wait_cnt--;
    for (int i = 0; i < N; i++)
      if (rdy_seen[i] && rhd[i] != rtail[i]) rhd[i]++;
    drive_reqs();
    drive_uart();
  endtask

  task automatic do_reset(input bit keep);
    reset = 1'b1;
    if (!keep) clear_reqs();
    model_reset();
    drive_reqs();
    drive_uart();
    @(negedge clk);
    chk("rst_req_ready",   32'(req_ready),   32'h0);
    chk("rst_uart_dat_we", 32'(uart_dat_we), 32'h0);
    chk("rst_uart_dat_di", uart_dat_di,      32'h0);
    chk("rst_busy",        32'(busy),        32'h0);
    chk("rst_grant_id",    32'(grant_id),    32'h0);
    chk("rst_lock_active", 32'(lock_active), 32'h0);
    @(posedge clk);
    #1;
    if (wait_cnt > 0) wait_cnt--;
    reset = 1'b0;
    drive_uart();
    dut_grant.delete();
    accept_cyc.delete();
    uart_log.delete();
  endtask

  task automatic drain_all(input int budget);
    int n;
    n = 0;
    while ((reqs_pending() || pend || drain_age != 0 || wait_cnt > 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) fail("drain_timeout");
  endtask

  // ---------------- table vectors (first IDLE cycle after reset) ----------------
  typedef struct {
    logic [N-1:0] valid;
    logic         wt;
    logic [N-1:0] ready;
  } vec_t;

  vec_t tbl[8];

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int exp_gap;
    logic [7:0] exp_b[5];
    logic [7:0] exp_l[4];
    int         exp_g[4];

    tbl[0] = '{4'b0001, 1'b0, 4'b0001};
    tbl[1] = '{4'b0110, 1'b0, 4'b0010};
    tbl[2] = '{4'b1000, 1'b0, 4'b1000};
    tbl[3] = '{4'b1111, 1'b0, 4'b0001};
    tbl[4] = '{4'b1010, 1'b1, 4'b0000};
    tbl[5] = '{4'b0000, 1'b0, 4'b0000};
    tbl[6] = '{4'b1100, 1'b0, 4'b0100};
    tbl[7] = '{4'b0101, 1'b1, 4'b0000};

    reset = 1'b1;
    req_valid = '0;
    req_data = '0;
    force_wait = 1'b0;
    rand_wait = 1'b0;
    wait_len = 0;
    wait_cnt = 0;
    uart_dat_wait = 1'b0;
    cyc = 0;
    clear_reqs();
    model_reset();
    @(posedge clk);
    #1;

    // Table: after reset the pointer is N-1, so the lowest valid wins
    // unless the UART is busy.
    for (int v = 0; v < 8; v++) begin
      reset = 1'b1;
      req_valid = '0;
      uart_dat_wait = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      req_valid = tbl[v].valid;
      req_data = 32'h34333231;
      uart_dat_wait = tbl[v].wt;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", v), 32'(req_ready), 32'(tbl[v].ready));
      chk($sformatf("tbl%0d_we", v),    32'(uart_dat_we), 32'h0);
      chk($sformatf("tbl%0d_busy", v),  32'(busy), 32'h0);
    end
    reset = 1'b1;
    req_valid = '0;
    uart_dat_wait = 1'b0;
    @(posedge clk);
    #1;

    // Reset with all valids held; requester 0 first with a 1-cycle pulse.
    clear_reqs();
    for (int i = 0; i < N; i++) push_byte(i, 8'(8'h61 + i));
    wait_len = 3;
    do_reset(1'b1);
    step();
    chk("first_grant", 32'(gl(0)), 32'(0));
    step();
    chk("first_pulse_len", 32'(dut_grant.size()), 32'(1));
    drain_all(500);

    // Four-way contention with a 10-cycle UART.
    clear_reqs();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push_byte(i, 8'(8'h41 + i));
    wait_len = 10;
    do_reset(1'b1);
    n = 0;
    while (uart_log.size() < 5 && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) fail("contention_timeout");
    exp_b = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h41};
    for (int i = 0; i < 5; i++) chk($sformatf("contention_byte%0d", i), 32'(ul(i)), 32'(exp_b[i]));
    for (int i = 0; i < 4; i++) chk($sformatf("contention_grant%0d", i), 32'(gl(i)), 32'(i));
    if (accept_cyc.size() >= 2)
      chk("accept_spacing", 32'(accept_cyc[1] - accept_cyc[0]), 32'(3 + 10));
    else fail("accept_spacing_missing");
    drain_all(500);

    // Write gating: the UART turns busy right after the accept.
    wait_len = 3;
    do_reset(1'b0);
    push_byte(2, 8'h5A);
    drive_reqs();
    n = 0;
    while (dut_grant.size() == 0 && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) fail("gate_accept_timeout");
    force_wait = 1'b1;
    drive_uart();
    for (int i = 0; i < 6; i++) step();
    chk("gated_no_strobe", 32'(uart_log.size()), 32'(0));
    force_wait = 1'b0;
    drive_uart();
    drain_all(100);
    chk("gated_one_byte", 32'(uart_log.size()), 32'(1));
    chk("gated_byte", 32'(ul(0)), 32'h5A);

    // Mid-frame reset during DRAIN.
    wait_len = 4;
    do_reset(1'b0);
    push_byte(1, 8'h11);
    push_byte(2, 8'h22);
    drive_reqs();
    n = 0;
    while (drain_age == 0 && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) fail("drain_reach_timeout");
    chk("pre_reset_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    chk("midreset_busy", 32'(busy), 32'h0);
    chk("midreset_di", uart_dat_di, 32'h0);
    chk("midreset_ready", 32'(req_ready), 32'h0);
    model_reset();
    push_byte(0, 8'h33);
    push_byte(3, 8'h44);
    drive_reqs();
    @(posedge clk);
    #1;
    cyc++;
    if (wait_cnt > 0) wait_cnt--;
    drive_uart();
    reset = 1'b0;
    dut_grant.delete();
    accept_cyc.delete();
    n = 0;
    while (dut_grant.size() == 0 && n < 30) begin
      step();
      n++;
    end
    chk("post_reset_grant", 32'(gl(0)), 32'(0));
    drain_all(200);

    // Line lock: req0 sends "AB\n" while req1 holds 'x'.
    wait_len = 2;
    do_reset(1'b0);
    push_byte(0, 8'h41);
    push_byte(0, 8'h42);
    push_byte(0, 8'h0A);
    push_byte(1, 8'h78);
    drive_reqs();
    drain_all(200);
`ifdef UART_ARB_LINE_LOCK_EN
    exp_l = '{8'h41, 8'h42, 8'h0A, 8'h78};
    exp_g = '{0, 0, 0, 1};
`else
    exp_l = '{8'h41, 8'h78, 8'h42, 8'h0A};
    exp_g = '{0, 1, 0, 0};
`endif
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("line_byte%0d", i), 32'(ul(i)), 32'(exp_l[i]));
      chk($sformatf("line_grant%0d", i), 32'(gl(i)), 32'(exp_g[i]));
    end

    // Lock timeout: req0 sends 'A' then goes quiet, req1 waits.
    wait_len = 2;
    do_reset(1'b0);
    push_byte(0, 8'h41);
    push_byte(1, 8'h78);
    drive_reqs();
    drain_all(200);
`ifdef UART_ARB_LINE_LOCK_EN
    exp_gap = 3 + 2 + LT;
`else
    exp_gap = 3 + 2;
`endif
    if (accept_cyc.size() >= 2)
      chk("timeout_gap", 32'(accept_cyc[1] - accept_cyc[0]), 32'(exp_gap));
    else fail("timeout_gap_missing");
    chk("timeout_grant1", 32'(gl(1)), 32'(1));

    // Randomized traffic with random UART frame lengths and dummy frames.
    rand_wait = 1'b1;
    do_reset(1'b0);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int r;
        logic [7:0] b;
        r = int'($urandom_range(0, N - 1));
        b = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
        if (rtail[r] - rhd[r] < 8) push_byte(r, b);
      end
      force_wait = ($urandom_range(0, 15) == 0);
      drive_reqs();
      drive_uart();
      step();
    end
    force_wait = 1'b0;
    drive_uart();
    drain_all(5000);
    chk("random_scoreboard_empty", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

- Shares the single UART transmit data register among `NUM_REQ` byte-stream requesters, for example several cores or a debug monitor plus firmware.
- Picks a requester round-robin and drives the UART write strobe and data.
- Respects the UART busy/wait signal, so the UART never silently drops a byte.
- Sits between the requester valid/ready ports and the UART `reg_dat_*` port; the UART divider port is not touched.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters, legal range 2..8.
- `LOCK_TIMEOUT`, 1024: idle cycles before a line lock is released. Used only with `UART_ARB_LINE_LOCK_EN`; legal range 1..65535.

Ports (`IW` = `$clog2(NUM_REQ)`):
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  byte pending per requester.
- `req_data`  in  8*NUM_REQ  byte i at bits [8i+7:8i].
- `req_ready`  out  NUM_REQ  one-hot; a pulse means the byte is accepted.
- `uart_dat_we`  out  1  UART data write strobe.
- `uart_dat_di`  out  32  UART write data, `{24'b0, byte}`.
- `uart_dat_wait`  in  1  UART busy (transmitting or in the post-config dummy frame).
- `busy`  out  1  arbiter holds an accepted byte or the UART is draining one.
- `grant_id`  out  IW  index of the most recently accepted requester.
- `lock_active`  out  1  line lock held; constant 0 without the macro.

## Operation

Requester handshake:
- Requester i raises `req_valid[i]` and holds `req_data` stable until `req_ready[i]` pulses.
- Transfer happens on the edge where `req_valid[i] && req_ready[i]`.

State machine (IDLE, ISSUE, DRAIN):
- **IDLE**
  - Eligible set = `req_valid`, masked to the lock owner while a lock is held.
  - If the set is non-empty and `uart_dat_wait==0`: the winner is the first eligible index searching upward from `last+1` (mod NUM_REQ).
  - `req_ready[winner]=1`, combinational; all other `req_ready` bits stay 0.
  - On the edge: `byte_q<=req_data[winner]`, `last<=winner`, `grant_id<=winner`, go to ISSUE.
- **ISSUE**
  - `uart_dat_we = !uart_dat_wait` (combinational).
  - When the strobe is high, go to DRAIN; otherwise stay. This covers a divider write re-arming the UART dummy frame after IDLE sampled.
- **DRAIN**
  - Exactly one cycle minimum, because the UART wait rises the cycle after the write.
  - From the second DRAIN cycle on, `uart_dat_wait==0` returns to IDLE.

Datapath:
- `uart_dat_di = {24'b0, byte_q}`, held in every state.
- `busy = (state != IDLE)`.

Arbitration rules:
- Fairness: no requester waits more than NUM_REQ-1 grants while its valid is held.
- Simultaneous valids are resolved by the rotating pointer only.
- A new valid arriving during ISSUE/DRAIN is considered at the next IDLE.

## Timing

Reset values:
- state=IDLE, `byte_q=0`, `last=NUM_REQ-1` so requester 0 wins first, lock cleared, timeout counter 0.
- Outputs: `uart_dat_we=0`, `uart_dat_di=0`, `req_ready=0`, `busy=0`, `grant_id=0`, `lock_active=0`.

Latency and throughput:
- Accept (IDLE, UART idle) to `uart_dat_we`: 1 cycle.
- Minimum accept-to-accept spacing: 3 cycles plus the UART wait time.
- Back-to-back frames leave no idle line time beyond the UART's own.

Reset mid-operation:
- Reset asserted in ISSUE or DRAIN returns to IDLE immediately and drops `byte_q`.
- The requester has already seen ready, so that byte is lost; this is accepted behaviour.

## Configuration

`UART_ARB_LINE_LOCK_EN` defined:
- After accepting a byte other than 0x0A from requester i, the arbiter locks to i and `lock_active=1`.
- The lock is released when:
  - a 0x0A byte from i is accepted, or
  - `LOCK_TIMEOUT` consecutive IDLE cycles pass with `req_valid[i]==0`.
- The timeout counter is 16 bits, cleared on each grant, and saturates.
- Release does not move the round-robin pointer.

Macro not defined:
- Lock register and counter are absent.
- `lock_active` is tied to 0.
- Pure per-byte round-robin.

## Test plan

- **Reset:** reset high with all valids set → every output at its reset value; after release, requester 0 is granted first with a 1-cycle `req_ready[0]` pulse.
- **Four-way contention:** valids 0..3 held, data 0x41..0x44, UART model wait=10 cycles → UART receives 0x41, 0x42, 0x43, 0x44, 0x41… and `grant_id` cycles 0,1,2,3.
- **Write gating:** wait held high (dummy frame) while ISSUE is pending → `uart_dat_we` stays 0 until wait falls, then exactly one strobe; no byte dropped or duplicated.
- **Line lock (macro on):** req0 sends "AB\n" while req1 is valid with 'x' → UART receives 'A','B',0x0A,'x'; `lock_active` is 1 from the accept of 'A' through the accept of 0x0A.
- **Lock timeout (macro on, LOCK_TIMEOUT=8):** req0 sends 'A' then drops valid, req1 valid → req1 is granted after 8 idle cycles; without the macro, req1 is granted immediately after 'A' drains.
- **Mid-frame reset:** reset pulsed during DRAIN → `busy=0` the same cycle; the next accepted byte goes to requester 0.
